// File: rtl/updn_cnt_mod_load.sv
// updn_cnt_mod_load
//   Up/down modulo counter with a run-time programmable terminal value,
//   wrap or saturate behaviour at the ends, a clamped parallel load and
//   combinational carry/borrow outputs for cascading stages.
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous active-high reset
//   i_ce         count enable (one step per cycle)
//   i_dir        1 = up, 0 = down
//   i_sat        0 = wrap at the ends, 1 = hold at the ends
//   i_load       parallel load of i_ld_data (clamped to the terminal value)
//   i_ld_data    load value
//   i_top_we     write a new terminal value
//   i_top_data   new terminal value (modulus - 1)
//   i_wrap_clr   clear the sticky wrapped flag
//   o_q          counter value (registered)
//   o_top        current terminal value (registered)
//   o_co         carry: stepping up from top this cycle (combinational)
//   o_bo         borrow: stepping down from 0 this cycle (combinational)
//   o_wrapped    sticky wrap-around flag (registered)
module updn_cnt_mod_load #(
  parameter int W      = 8,
  parameter int MODULO = 10
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_ce,
  input  logic         i_dir,
  input  logic         i_sat,
  input  logic         i_load,
  input  logic [W-1:0] i_ld_data,
  input  logic         i_top_we,
  input  logic [W-1:0] i_top_data,
  input  logic         i_wrap_clr,
  output logic [W-1:0] o_q,
  output logic [W-1:0] o_top,
  output logic         o_co,
  output logic         o_bo,
  output logic         o_wrapped
);

  // MODULO may equal 2^W, so truncate after the subtraction.
  localparam logic [W-1:0] TOP_RST = W'(MODULO - 1);

  logic [W-1:0] r_q, r_top;
  logic         r_wrapped;

  logic [W-1:0] w_term;     // terminal value in force this cycle
  logic [W-1:0] w_ld_clamp;
  logic [W-1:0] w_q_clamp;  // current q clamped to a newly written top
  logic         w_step;     // a count step is allowed this cycle
  logic         w_at_top, w_at_zero;

  assign w_term     = i_top_we ? i_top_data : r_top;
  assign w_ld_clamp = (i_ld_data > w_term) ? w_term : i_ld_data;
  assign w_q_clamp  = (r_q > i_top_data) ? i_top_data : r_q;
  assign w_at_top   = (r_q == r_top);
  assign w_at_zero  = (r_q == '0);
  assign w_step     = i_ce & ~i_rst & ~i_load & ~i_top_we;

  // Carry/borrow depend only on registered state and control inputs, so a
  // cascaded stage sees them in the same cycle and steps on the same edge.
  assign o_co = w_step &  i_dir & w_at_top;
  assign o_bo = w_step & ~i_dir & w_at_zero;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_q       <= '0;
      r_top     <= TOP_RST;
      r_wrapped <= 1'b0;
    end else begin
      if (i_top_we)
        r_top <= i_top_data;

      if (i_load)
        r_q <= w_ld_clamp;
      else if (i_top_we)
        r_q <= w_q_clamp;
      else if (i_ce) begin
        if (i_dir) begin
          if (!w_at_top)   r_q <= r_q + 1'b1;
          else if (!i_sat) r_q <= '0;
        end else begin
          if (!w_at_zero)  r_q <= r_q - 1'b1;
          else if (!i_sat) r_q <= r_top;
        end
      end

      // Set beats clear when both happen in the same cycle.
      if (!i_sat && (o_co || o_bo))
        r_wrapped <= 1'b1;
      else if (i_wrap_clr)
        r_wrapped <= 1'b0;
    end
  end

  assign o_q       = r_q;
  assign o_top     = r_top;
  assign o_wrapped = r_wrapped;

endmodule

// File: tb/tb_updn_cnt_mod_load.sv
// Directed bench for updn_cnt_mod_load (W=4, MODULO=10), plus a two-stage
// decade cascade where the lower stage's carry enables the upper stage.
module tb_updn_cnt_mod_load;

  logic       clk = 1'b0;
  logic       rst, ce, dir, sat, load, top_we, wrap_clr;
  logic [3:0] ld_data, top_data;
  logic [3:0] q, top;
  logic       co, bo, wrapped;

  logic       c_rst, c_ce;
  logic [3:0] lo_q, lo_top, hi_q, hi_top;
  logic       lo_co, lo_bo, lo_wr, hi_co, hi_bo, hi_wr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  updn_cnt_mod_load #(.W(4), .MODULO(10)) dut (
    .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_dir(dir), .i_sat(sat),
    .i_load(load), .i_ld_data(ld_data), .i_top_we(top_we),
    .i_top_data(top_data), .i_wrap_clr(wrap_clr),
    .o_q(q), .o_top(top), .o_co(co), .o_bo(bo), .o_wrapped(wrapped)
  );

  updn_cnt_mod_load #(.W(4), .MODULO(10)) u_lo (
    .i_clk(clk), .i_rst(c_rst), .i_ce(c_ce), .i_dir(1'b1), .i_sat(1'b0),
    .i_load(1'b0), .i_ld_data(4'd0), .i_top_we(1'b0),
    .i_top_data(4'd0), .i_wrap_clr(1'b0),
    .o_q(lo_q), .o_top(lo_top), .o_co(lo_co), .o_bo(lo_bo), .o_wrapped(lo_wr)
  );

  updn_cnt_mod_load #(.W(4), .MODULO(10)) u_hi (
    .i_clk(clk), .i_rst(c_rst), .i_ce(lo_co), .i_dir(1'b1), .i_sat(1'b0),
    .i_load(1'b0), .i_ld_data(4'd0), .i_top_we(1'b0),
    .i_top_data(4'd0), .i_wrap_clr(1'b0),
    .o_q(hi_q), .o_top(hi_top), .o_co(hi_co), .o_bo(hi_bo), .o_wrapped(hi_wr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks land between edges.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; ce = 0; dir = 1; sat = 0; load = 0; top_we = 0; wrap_clr = 0;
    ld_data = 0; top_data = 0;
  endtask

  initial begin
    idle();
    rst = 1; c_rst = 1; c_ce = 0;
    tick();
    rst = 0; c_rst = 0;
    chk("rst_q", q, 0);
    chk("rst_top", top, 9);
    chk("rst_wrapped", wrapped, 0);

    // Count up through a wrap.
    ce = 1; dir = 1; sat = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      chk("up_q", q, i % 10);
      chk("up_co", co, (i % 10) == 9);
      chk("up_wrapped", wrapped, i >= 10);
      tick();
    end
    chk("up_q_end", q, 2);

    // Down wrap from 0.
    idle(); rst = 1; tick(); rst = 0;
    ce = 1; dir = 0; sat = 0;
    #1 chk("dn_bo0", bo, 1);
    tick(); chk("dn_q9", q, 9); chk("dn_bo1", bo, 0); chk("dn_wr", wrapped, 1);
    tick(); chk("dn_q8", q, 8); chk("dn_bo2", bo, 0);
    tick(); chk("dn_q7", q, 7);

    // Saturate at 0.
    idle(); rst = 1; tick(); rst = 0;
    ce = 1; dir = 0; sat = 1;
    for (int i = 0; i < 3; i++) begin
      #1 chk("sat_bo", bo, 1);
      tick();
      chk("sat_q", q, 0);
      chk("sat_wr", wrapped, 0);
    end

    // Clamped loads.
    idle(); load = 1; ld_data = 13;
    tick(); chk("ld_clamp", q, 9);
    ld_data = 4; ce = 1; dir = 1;
    #1 chk("ld_co", co, 0);
    tick(); chk("ld_q4", q, 4);
    load = 0;
    tick(); chk("ld_next", q, 5);

    // Terminal reprogram.
    idle(); load = 1; ld_data = 8; tick(); chk("tw_pre", q, 8);
    load = 0; top_we = 1; top_data = 5; ce = 1; dir = 1;
    #1 chk("tw_co", co, 0);
    tick(); chk("tw_q", q, 5); chk("tw_top", top, 5);
    top_we = 0;
    #1 chk("tw_co5", co, 1);
    tick(); chk("tw_wrap", q, 0);
    idle(); load = 1; ld_data = 7; top_we = 1; top_data = 3;
    tick(); chk("tw_ld_q", q, 3); chk("tw_ld_top", top, 3);

    // top = 0: q pinned at 0, co/bo every cycle.
    idle(); top_we = 1; top_data = 0;
    tick(); chk("t0_q", q, 0);
    idle(); wrap_clr = 1; tick(); wrap_clr = 0;
    chk("t0_clr", wrapped, 0);
    ce = 1; dir = 1;
    #1 chk("t0_co", co, 1);
    tick(); chk("t0_q_up", q, 0); chk("t0_wr", wrapped, 1);
    dir = 0;
    #1 chk("t0_bo", bo, 1);
    tick(); chk("t0_q_dn", q, 0);

    // Sticky flag: set wins over clear.
    idle(); top_we = 1; top_data = 9; tick();
    idle(); load = 1; ld_data = 9; tick();
    idle(); wrap_clr = 1; tick(); chk("wc_clr", wrapped, 0);
    ce = 1; dir = 1; wrap_clr = 1;
    #1 chk("wc_co", co, 1);
    tick(); chk("wc_set_wins", wrapped, 1); chk("wc_q", q, 0);
    idle(); load = 1; ld_data = 2; top_we = 1; top_data = 4;
    tick(); chk("wc_keep", wrapped, 1); chk("wc_lq", q, 2); chk("wc_top", top, 4);

    // Reset beats load and top_we.
    idle(); rst = 1; load = 1; ld_data = 7; top_we = 1; top_data = 3; ce = 1;
    tick(); idle();
    chk("rp_q", q, 0); chk("rp_top", top, 9); chk("rp_wr", wrapped, 0);

    // Decade cascade: 37 steps then on to 100.
    c_ce = 1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      chk("cas_lo", lo_q, k % 10);
      chk("cas_hi", hi_q, (k / 10) % 10);
      if (k == 37) begin
        chk("cas37_hi", hi_q, 3);
        chk("cas37_lo", lo_q, 7);
      end
    end
    c_ce = 0;
    chk("cas100_lo", lo_q, 0);
    chk("cas100_hi", hi_q, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/updn_cnt_mod_load.md
# updn_cnt_mod_load

Parametrised up/down modulo counter with a run-time programmable terminal value, wrap or saturate mode, a clamped parallel load, and combinational carry/borrow outputs for cascading. It is the general counter primitive for the synth datapath: prescalers, step and sequencer indices, envelope timers, and multi-digit cascades where one stage's carry drives the next stage's enable.

## Interface
Parameters:
- W, 8, counter and terminal-value width in bits; W >= 1.
- MODULO, 10, reset modulus. The reset terminal value is MODULO-1. Legal range is 1..2^W.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ce  in  1  count enable, one step per cycle while high.
- dir  in  1  1 = count up, 0 = count down.
- sat  in  1  0 = wrap at the ends, 1 = saturate (hold) at the ends.
- load  in  1  parallel load of ld_data.
- ld_data  in  W  load value; clamped to the effective terminal value.
- top_we  in  1  write a new terminal value.
- top_data  in  W  new terminal value, equal to modulus minus 1.
- wrap_clr  in  1  clears the wrapped flag.
- q  out  W  counter value (registered).
- top  out  W  current terminal value (registered).
- co  out  1  carry: the counter is stepping up from top this cycle (combinational).
- bo  out  1  borrow: the counter is stepping down from 0 this cycle (combinational).
- wrapped  out  1  sticky flag: a wrap-around has occurred (registered).

## Operation
Priority order per cycle: rst, then load, then top_we, then ce.

- **rst**
  - q = 0, top = MODULO-1, wrapped = 0.
  - All other inputs are ignored in that cycle.
- **top_we** (no rst)
  - top <= top_data.
  - Effective terminal for this cycle: T = top_we ? top_data : top.
- **load**
  - q <= min(ld_data, T). The comparison is unsigned.
  - No counting occurs that cycle. wrapped is unchanged.
- **top_we without load**
  - q <= min(q, top_data).
  - Counting is suppressed that cycle.
- **ce, dir=1** (no rst/load/top_we)
  - If q != top: q <= q+1.
  - If q == top: q <= 0 when sat=0, or q holds when sat=1.
- **ce, dir=0** (no rst/load/top_we)
  - If q != 0: q <= q-1.
  - If q == 0: q <= top when sat=0, or q holds when sat=1.
- **ce=0:** q holds.
- **co** = ce & dir & (q == top) & ~rst & ~load & ~top_we. It asserts in saturate mode as well.
- **bo** = ce & ~dir & (q == 0) & ~rst & ~load & ~top_we.
- **wrapped**
  - Set on any cycle where sat=0 and (co | bo).
  - wrap_clr clears it. If a set and wrap_clr happen in the same cycle, the set wins.
  - load and top_we do not affect it.
- **Arithmetic:** all W-bit unsigned. q never exceeds top after any clock edge.
- **top = 0:** q stays 0.
  - ce with dir=1 gives co every cycle; ce with dir=0 gives bo every cycle.
  - wrapped sets when sat=0.
- **top = 2^W-1:** natural binary rollover. No special case.

## Timing
- q, top and wrapped change only on the rising clk edge. Each has 1-cycle latency from its controlling input.
- co and bo are combinational from ce, dir, load, top_we, rst and the registered q and top. They are valid in the same cycle as ce.
- Cascade by tying co of stage n to ce of stage n+1 (with dir=1). Use bo for down-counting cascades.
  - The upper stage steps on the same edge that the lower stage wraps. No extra latency.
- There is no combinational path from ld_data or top_data to any output.
- After a load, an immediate next-cycle ce counts from the loaded (clamped) value.
- Reset mid-count takes effect at the next edge; outputs read their reset values from the following cycle onward.

## Test plan
- **Reset and wrap up:** W=4, MODULO=10, rst for 1 cycle, then ce=1, dir=1, sat=0 for 12 cycles.
  - q: 0,1..9,0,1,2.
  - co high only while q=9.
  - wrapped=1 from the cycle after the co pulse.
- **Down wrap and saturate:** q=0, top=9.
  - dir=0, sat=0, ce for 3 cycles: q 9,8,7; bo high only in the first cycle.
  - Then sat=1 from q=0: q holds 0, bo high every ce cycle, wrapped does not set.
- **Clamped load:** top=9.
  - load with ld_data=13: q=9.
  - load with ld_data=4 together with ce=1, dir=1: q=4 and co=0.
  - The next ce cycle gives q=5.
- **Terminal reprogram:** q=8, top=9.
  - top_we with top_data=5 and ce=1: q=5, top=5, co=0.
  - Then counting up gives 0 after 5.
  - load with ld_data=7 and top_we with top_data=3 in the same cycle: q=3.
- **Cascade:** two instances, W=4, MODULO=10, lower co driving upper ce.
  - 100 ce cycles return both stages to 0.
  - Upper stage steps exactly on lower 9->0 edges.
  - After 37 ce cycles the stages read 3 (upper) and 7 (lower).
- **Sticky flag and reset priority:**
  - wrap_clr in the same cycle as a wrap event: wrapped stays 1.
  - rst together with load=1 and top_we=1: q=0, top=9, wrapped=0.
